// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
//
// Shares a single ALU between NUM_REQ command sources. One command is taken
// at a time: a round-robin arbiter picks a requester in IDLE, the operands
// and function code are registered toward the ALU, a one-cycle ALU_EN strobe
// issues the operation, and the scheduler waits for ALU_OUT_VALID or a
// TIMEOUT-cycle timeout. The result (or an error marker) is returned with
// the owning requester's index over a valid/ready response channel.
//
// Ports
//   CLK            rising-edge clock
//   RST            synchronous active-high reset
//   REQ_VALID      per-requester command valid            [NUM_REQ]
//   REQ_READY      per-requester accept (one-hot or zero)  [NUM_REQ]
//   REQ_A/REQ_B    operands, requester i at slice i        [NUM_REQ*DATA_WIDTH]
//   REQ_FUN        function code, slice i                  [NUM_REQ*4]
//   ALU_A/ALU_B    registered operands to the ALU          [DATA_WIDTH]
//   ALU_FUN        registered function code to the ALU     [4]
//   ALU_EN         one-cycle issue strobe
//   ALU_OUT        ALU result                              [DATA_WIDTH]
//   ALU_OUT_VALID  ALU result valid (only honoured while waiting)
//   RSP_VALID      response valid
//   RSP_READY      response consumer ready
//   RSP_ID         requester owning the response           [IDW]
//   RSP_DATA       result, zero on timeout                 [DATA_WIDTH]
//   RSP_ERR        1 = timeout, no ALU result
//   BUSY           1 whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module alu_rr_scheduler #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 16,
    parameter int  TIMEOUT    = 8,
    localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_A,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_B,
    input  logic [NUM_REQ*4-1:0]          REQ_FUN,
    output logic [DATA_WIDTH-1:0]         ALU_A,
    output logic [DATA_WIDTH-1:0]         ALU_B,
    output logic [3:0]                    ALU_FUN,
    output logic                          ALU_EN,
    input  logic [DATA_WIDTH-1:0]         ALU_OUT,
    input  logic                          ALU_OUT_VALID,
    output logic                          RSP_VALID,
    input  logic                          RSP_READY,
    output logic [IDW-1:0]                RSP_ID,
    output logic [DATA_WIDTH-1:0]         RSP_DATA,
    output logic                          RSP_ERR,
    output logic                          BUSY
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // One extra bit so pointer+offset never overflows before the wrap.
    localparam int SW   = IDW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e                  state_q,     state_d;
    logic [IDW-1:0]          ptr_q,       ptr_d;
    logic [CNTW-1:0]         cnt_q,       cnt_d;
    logic [DATA_WIDTH-1:0]   alu_a_q,     alu_a_d;
    logic [DATA_WIDTH-1:0]   alu_b_q,     alu_b_d;
    logic [3:0]              alu_fun_q,   alu_fun_d;
    logic                    alu_en_q,    alu_en_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]          rsp_id_q,    rsp_id_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q,  rsp_data_d;
    logic                    rsp_err_q,   rsp_err_d;
    logic                    busy_q,      busy_d;

    logic [IDW-1:0]          grant_s;
    logic                    grant_vld_s;
    logic [NUM_REQ-1:0]      req_ready_s;

    // Round-robin grant: first valid requester at or above the pointer,
    // wrapping. Scanning offsets from highest to lowest lets the smallest
    // offset overwrite the others, so no "found" flag is needed.
    always_comb begin
        logic [SW-1:0] sum_v;
        logic [IDW-1:0] idx_v;
        grant_s     = '0;
        grant_vld_s = 1'b0;
        sum_v       = '0;
        idx_v       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum_v = {1'b0, ptr_q} + SW'(k);
            if (sum_v >= SW'(NUM_REQ)) begin
                sum_v = sum_v - SW'(NUM_REQ);
            end else begin
                sum_v = sum_v;
            end
            idx_v = sum_v[IDW-1:0];
            if (REQ_VALID[idx_v]) begin
                grant_s     = idx_v;
                grant_vld_s = 1'b1;
            end else begin
                grant_s     = grant_s;
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Accept is combinational so the requester sees it in the grant cycle.
    always_comb begin
        req_ready_s = '0;
        if ((state_q == ST_IDLE) && grant_vld_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Next-state and datapath updates; every register holds by default.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_fun_d  = alu_fun_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    alu_a_d   = REQ_A[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH];
                    alu_b_d   = REQ_B[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH];
                    alu_fun_d = REQ_FUN[int'(grant_s)*4 +: 4];
                    rsp_id_d  = grant_s;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result on the final allowed cycle still wins over timeout.
                if (ALU_OUT_VALID) begin
                    rsp_data_d = ALU_OUT;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d      = cnt_q + CNTW'(1);
                    state_d    = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    // Next search starts just after the requester just served.
                    if (rsp_id_q == IDW'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = rsp_id_q + IDW'(1);
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered decodes of the upcoming state.
        alu_en_d    = (state_d == ST_ISSUE);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= 4'd0;
            alu_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            alu_en_q    <= alu_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign REQ_READY = req_ready_s;
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_FUN   = alu_fun_q;
    assign ALU_EN    = alu_en_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ID    = rsp_id_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign BUSY      = busy_q;

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Round-robin scheduler that shares one ALU (arith/logic/cmp/shift units selected by a 4-bit function code) between NUM_REQ requesters. It accepts one command at a time over a valid/ready handshake, issues it to the ALU with a single-cycle enable strobe, and waits for the ALU result or a timeout. It then returns the result, tagged with the requester ID, over a response handshake. It sits between the command sources and the ALU top, and drives the function code that feeds the ALU's unit decoder.

Parameters:
NUM_REQ, 4, number of requesters (2..8); ID width IDW = clog2(NUM_REQ)
DATA_WIDTH, 16, operand and result width
TIMEOUT, 8, maximum WAIT cycles before an error response (>=1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous reset, active-high
REQ_VALID  input  NUM_REQ  per-requester command valid
REQ_READY  output  NUM_REQ  per-requester accept, one-hot or zero
REQ_A  input  NUM_REQ*DATA_WIDTH  operand A, requester i at slice i
REQ_B  input  NUM_REQ*DATA_WIDTH  operand B, slice i
REQ_FUN  input  NUM_REQ*4  function code, slice i; [3:2] selects unit, [1:0] selects op
ALU_A  output  DATA_WIDTH  registered operand A to ALU
ALU_B  output  DATA_WIDTH  registered operand B to ALU
ALU_FUN  output  4  registered function code to ALU
ALU_EN  output  1  one-cycle issue strobe
ALU_OUT  input  DATA_WIDTH  ALU result
ALU_OUT_VALID  input  1  ALU result valid
RSP_VALID  output  1  response valid
RSP_READY  input  1  response consumer ready
RSP_ID  output  IDW  index of the requester owning the response
RSP_DATA  output  DATA_WIDTH  result, or 0 on error
RSP_ERR  output  1  1 = timeout, no ALU result
BUSY  output  1  1 in any state other than IDLE

Behaviour:
- RST is synchronous and active-high. When CLK rises with RST=1:
  - state = IDLE and the round-robin pointer = 0.
  - ALU_A, ALU_B, ALU_FUN, RSP_DATA, RSP_ID, RSP_ERR = 0.
  - ALU_EN, RSP_VALID, BUSY = 0.
  - The timeout counter = 0.
  - RST mid-operation abandons the in-flight command. No response is produced for it.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant g is the first i with REQ_VALID[i]=1, scanning from the pointer upward and wrapping modulo NUM_REQ.
  - REQ_READY[g]=1 combinationally. It is 0 in all other states, and 0 when no request is valid.
  - On the edge, latch REQ_A/REQ_B/REQ_FUN slice g into ALU_A/ALU_B/ALU_FUN and g into RSP_ID, then go to ISSUE.
- ISSUE: ALU_EN=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - ALU_OUT_VALID is sampled only in this state. It is ignored in IDLE, ISSUE and RESP.
  - If ALU_OUT_VALID=1: RSP_DATA<=ALU_OUT, RSP_ERR<=0, go to RESP.
  - Else if counter == TIMEOUT-1: RSP_DATA<=0, RSP_ERR<=1, go to RESP.
  - Else increment the counter.
  - If ALU_OUT_VALID arrives on the timeout cycle, the valid result wins (no error).
- RESP:
  - RSP_VALID=1. RSP_ID, RSP_DATA and RSP_ERR are held stable until RSP_READY=1.
  - On the handshake edge: pointer <= (RSP_ID+1) mod NUM_REQ, go to IDLE.
- Minimum command period is 4 cycles (IDLE, ISSUE, WAIT, RESP), with ALU result 1 cycle after ALU_EN and RSP_READY already high.
- ALU_A/ALU_B/ALU_FUN hold their value after issue until the next grant.
- A requester must hold REQ_VALID and its slices stable until it sees REQ_READY.
- A request dropped before grant is never served. Requests arriving while not in IDLE wait.
- No starvation: with all requesters valid continuously, grant order is pointer, pointer+1, ... with wrap; each requester is served once per NUM_REQ commands.

Test Plan:
1. Reset, then single request:
   - Stimulus: REQ_VALID=0001, A=0x0005, B=0x0003, FUN=0x0 (add); ALU returns 0x0008 one cycle after ALU_EN.
   - Response: REQ_READY=0001 in IDLE; ALU_EN high exactly 1 cycle with ALU_A=5, ALU_B=3, ALU_FUN=0; RSP_VALID with RSP_ID=0, RSP_DATA=0x0008, RSP_ERR=0 on the 4th cycle after request.
2. All four requesters valid continuously, RSP_READY=1:
   - Response: grants in order 0,1,2,3,0; REQ_READY never multi-hot; pointer wraps 3->0.
3. Grant to requester 2, then REQ_VALID=1011:
   - Response: next grant goes to 3, then 0, not 1 or 0 first.
4. ALU_OUT_VALID never asserted, TIMEOUT=8:
   - Response: RSP_VALID exactly 8 cycles after entering WAIT, with RSP_ERR=1 and RSP_DATA=0.
   - Variant with ALU_OUT_VALID on that 8th cycle: RSP_ERR=0 and RSP_DATA=ALU_OUT.
5. RSP_READY held low 5 cycles in RESP:
   - Response: RSP_* stable throughout; no REQ_READY, no ALU_EN; after RSP_READY=1, back to IDLE and the next grant proceeds.
   - A stray ALU_OUT_VALID pulse during RESP and during IDLE changes nothing.
6. RST=1 asserted in WAIT:
   - Response: next cycle BUSY=0, RSP_VALID=0, outputs at reset values, pointer=0; a later ALU_OUT_VALID is ignored; the next request from requester 0 is served normally.
